apb_wait_slave: RTL and testbench



---
 rtl/apb_wait_slave_pkg.sv | 12 +
 rtl/apb_wait_slave_regfile.sv | 40 ++++
 rtl/apb_wait_slave.sv | 126 ++++++++++++
 tb/tb_apb_wait_slave.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/apb_wait_slave_pkg.sv
// Shared types and bus constants for the APB wait-state completer.
package apb_wait_slave_pkg;
  localparam int APB_DATA_W = 32;
  localparam int APB_ADDR_W = 32;
  localparam int ADDR_LSB   = 2;
  localparam int CNT_W      = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;
endpackage

// File: rtl/apb_wait_slave_regfile.sv
// Register file: read-only ID word at index 0, read/write words above it.
module apb_wait_slave_regfile
  import apb_wait_slave_pkg::*;
#(
  parameter int                    NUM_REGS = 8,
  parameter logic [APB_DATA_W-1:0] ID_VALUE = 32'hA9B0_0001,
  localparam int                   IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           we_i,
  input  logic [IDX_W-1:0]               widx_i,
  input  logic [APB_DATA_W-1:0]          wdata_i,
  input  logic [IDX_W-1:0]               ridx_i,
  output logic [APB_DATA_W-1:0]          rdata_o,
  output logic [NUM_REGS*APB_DATA_W-1:0] regs_o
);

  logic [APB_DATA_W-1:0] word [NUM_REGS];

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (i == 0) begin : g_id
      assign word[i] = ID_VALUE;
    end else begin : g_rw
      logic [APB_DATA_W-1:0] q;
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          q <= '0;
        end else if (we_i && (widx_i == IDX_W'(i))) begin
          q <= wdata_i;
        end
      end
      assign word[i] = q;
    end
    assign regs_o[APB_DATA_W*i +: APB_DATA_W] = word[i];
  end

  assign rdata_o = word[ridx_i];

endmodule

// File: rtl/apb_wait_slave.sv
// APB completer with a fixed number of wait states and a sticky protocol-error flag.
module apb_wait_slave
  import apb_wait_slave_pkg::*;
#(
  parameter int                    NUM_REGS    = 8,
  parameter int                    WAIT_CYCLES = 0,
  parameter logic [APB_DATA_W-1:0] ID_VALUE    = 32'hA9B0_0001
) (
  input  logic                           PCLK,
  input  logic                           PRESET,
  input  logic                           PSEL,
  input  logic                           PENABLE,
  input  logic                           PWRITE,
  input  logic [APB_ADDR_W-1:0]          PADDR,
  input  logic [APB_DATA_W-1:0]          PWDATA,
  output logic [APB_DATA_W-1:0]          PRDATA,
  output logic                           PREADY,
  output logic [NUM_REGS*APB_DATA_W-1:0] regs_o,
  output logic                           prot_err
);

  localparam int IDX_W = $clog2(NUM_REGS);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  pready_q, pready_d;
  logic [APB_DATA_W-1:0] prdata_q, prdata_d;
  logic                  err_q, err_d;
  logic                  write_q, write_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  inrng_q, inrng_d;

  logic                  reg_we;
  logic [APB_DATA_W-1:0] rf_rdata;
  logic [IDX_W-1:0]      addr_idx;
  logic                  addr_inrng;
  logic                  unused_addr_bits;

  assign addr_idx         = PADDR[IDX_W+ADDR_LSB-1:ADDR_LSB];
  assign addr_inrng       = (PADDR[APB_ADDR_W-1:IDX_W+ADDR_LSB] == '0);
  // Byte lane bits carry no meaning for whole-word registers.
  assign unused_addr_bits = ^PADDR[ADDR_LSB-1:0];

  apb_wait_slave_regfile #(
    .NUM_REGS (NUM_REGS),
    .ID_VALUE (ID_VALUE)
  ) u_regfile (
    .clk_i   (PCLK),
    .rst_i   (PRESET),
    .we_i    (reg_we),
    .widx_i  (idx_q),
    .wdata_i (PWDATA),
    .ridx_i  (addr_idx),
    .rdata_o (rf_rdata),
    .regs_o  (regs_o)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prdata_d = prdata_q;
    err_d    = err_q;
    write_d  = write_q;
    idx_d    = idx_q;
    inrng_d  = inrng_q;
    reg_we   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          state_d = ACCESS;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          write_d = PWRITE;
          idx_d   = addr_idx;
          inrng_d = addr_inrng;
          // Read data is captured at setup so PRDATA comes straight from a flop.
          if (!PWRITE) prdata_d = addr_inrng ? rf_rdata : '0;
        end else if (PSEL && PENABLE) begin
          err_d = 1'b1;
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (PENABLE) begin
          if (cnt_q == '0) begin
            reg_we  = write_q && inrng_q;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // PREADY is registered, so it is computed from the next state.
    pready_d = (state_d == ACCESS) && (cnt_d == '0);
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pready_q <= 1'b0;
      prdata_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pready_q <= pready_d;
      prdata_q <= prdata_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge PCLK) begin
    write_q <= write_d;
    idx_q   <= idx_d;
    inrng_q <= inrng_d;
  end

  assign PREADY   = pready_q;
  assign PRDATA   = prdata_q;
  assign prot_err = err_q;

endmodule

// File: tb/tb_apb_wait_slave.sv
// Bench for apb_wait_slave: two instances (0 and 3 wait states) against a transaction-level model.
module tb_apb_wait_slave;

  localparam int          NR = 8;
  localparam logic [31:0] ID = 32'hA9B0_0001;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          psel    [2];
  logic          penable [2];
  logic          pwrite  [2];
  logic [31:0]   paddr   [2];
  logic [31:0]   pwdata  [2];
  logic [31:0]   prdata  [2];
  logic          pready  [2];
  logic [255:0]  regs    [2];
  logic          err     [2];

  apb_wait_slave #(.NUM_REGS(NR), .WAIT_CYCLES(0), .ID_VALUE(ID)) dut0 (
    .PCLK(clk), .PRESET(rst), .PSEL(psel[0]), .PENABLE(penable[0]), .PWRITE(pwrite[0]),
    .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PRDATA(prdata[0]), .PREADY(pready[0]),
    .regs_o(regs[0]), .prot_err(err[0]));

  apb_wait_slave #(.NUM_REGS(NR), .WAIT_CYCLES(3), .ID_VALUE(ID)) dut1 (
    .PCLK(clk), .PRESET(rst), .PSEL(psel[1]), .PENABLE(penable[1]), .PWRITE(pwrite[1]),
    .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PRDATA(prdata[1]), .PREADY(pready[1]),
    .regs_o(regs[1]), .prot_err(err[1]));

  // Reference model state
  int          wc [2] = '{0, 3};
  logic [31:0] mregs [2][NR];
  logic        exp_pready [2];
  logic [31:0] exp_prdata [2];
  logic        exp_err [2];
  bit          started = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int k, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[dut%0d] at %0t: got %h expected %h", name, k, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] mread(input int k, input logic [31:0] a);
    if (a[31:5] != 27'd0) return 32'h0;
    if (a[4:2] == 3'd0) return ID;
    return mregs[k][a[4:2]];
  endfunction

  task automatic mwrite(input int k, input logic [31:0] a, input logic [31:0] d);
    if (a[31:5] == 27'd0 && a[4:2] != 3'd0) mregs[k][a[4:2]] = d;
  endtask

  function automatic logic [255:0] mflat(input int k);
    logic [255:0] f;
    for (int i = 0; i < NR; i++) f[32*i +: 32] = (i == 0) ? ID : mregs[k][i];
    return f;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NR; i++) mregs[k][i] = 32'h0;
      exp_pready[k] = 1'b0;
      exp_prdata[k] = 32'h0;
      exp_err[k]    = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        chk("pready",   k, 256'(pready[k]), 256'(exp_pready[k]));
        chk("prdata",   k, 256'(prdata[k]), 256'(exp_prdata[k]));
        chk("regs_o",   k, regs[k],          mflat(k));
        chk("prot_err", k, 256'(err[k]),     256'(exp_err[k]));
      end
    end
  end

  // Full transfer starting just after a rising edge; returns PRDATA and the number of
  // access cycles PREADY was seen low.
  task automatic xfer(input int k, input bit wr, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output int lows);
    lows = 0;
    rd   = 32'h0;
    psel[k] = 1'b1; penable[k] = 1'b0; pwrite[k] = wr; paddr[k] = a; pwdata[k] = d;
    @(posedge clk); #1;
    if (!wr) exp_prdata[k] = mread(k, a);
    penable[k] = 1'b1;
    for (int i = 0; i <= wc[k]; i++) begin
      exp_pready[k] = (i == wc[k]);
      @(negedge clk);
      if (pready[k] !== 1'b1) lows++;
      rd = prdata[k];
      @(posedge clk); #1;
    end
    if (wr) mwrite(k, a, d);
    exp_pready[k] = 1'b0;
    psel[k] = 1'b0; penable[k] = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  logic [31:0] rd;
  int          lows;

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      psel[k] = 1'b0; penable[k] = 1'b0; pwrite[k] = 1'b0; paddr[k] = 32'h0; pwdata[k] = 32'h0;
    end
    model_reset();
    @(posedge clk); #1;
    started = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);

    // ID register read and write-protect
    xfer(0, 1'b0, 32'h0, 32'h0, rd, lows);
    chk("id_read", 0, 256'(rd), 256'(32'hA9B0_0001));
    chk("id_lat0", 0, 256'(lows), 256'(0));
    xfer(0, 1'b1, 32'h0, 32'h1234_5678, rd, lows);
    xfer(0, 1'b0, 32'h0, 32'h0, rd, lows);
    chk("id_ro", 0, 256'(rd), 256'(32'hA9B0_0001));

    // Plain read/write, back-to-back
    xfer(0, 1'b1, 32'h4, 32'hCAFE_F00D, rd, lows);
    xfer(0, 1'b0, 32'h4, 32'h0, rd, lows);
    chk("rw_rd", 0, 256'(rd), 256'(32'hCAFE_F00D));
    chk("rw_reg1", 0, 256'(regs[0][63:32]), 256'(32'hCAFE_F00D));
    chk("rw_others", 0, 256'(regs[0][255:64]), 256'(0));

    // Wait states
    idle(1);
    xfer(1, 1'b1, 32'h8, 32'h5555_AAAA, rd, lows);
    chk("wait_lows", 1, 256'(lows), 256'(3));
    chk("wait_reg2", 1, 256'(regs[1][95:64]), 256'(32'h5555_AAAA));

    // Out of range
    xfer(0, 1'b1, 32'h20, 32'hFFFF_FFFF, rd, lows);
    xfer(0, 1'b0, 32'h20, 32'h0, rd, lows);
    chk("oor_rd", 0, 256'(rd), 256'(0));
    chk("oor_lat", 0, 256'(lows), 256'(0));

    // Access without setup
    psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b0; paddr[0] = 32'h4;
    @(posedge clk); #1;
    exp_err[0] = 1'b1;
    psel[0] = 1'b0; penable[0] = 1'b0;
    @(negedge clk);
    chk("nosetup_err", 0, 256'(err[0]), 256'(1));
    chk("nosetup_rdy", 0, 256'(pready[0]), 256'(0));
    #1;

    // Abort mid-wait
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 32'h10; pwdata[1] = 32'h7777_7777;
    @(posedge clk); #1;
    penable[1] = 1'b1;
    @(posedge clk); #1;
    psel[1] = 1'b0; penable[1] = 1'b0;
    @(posedge clk); #1;
    exp_err[1] = 1'b1;
    xfer(1, 1'b0, 32'h10, 32'h0, rd, lows);
    chk("abort_rd", 1, 256'(rd), 256'(0));
    chk("abort_lows", 1, 256'(lows), 256'(3));
    chk("abort_err", 1, 256'(err[1]), 256'(1));

    // Reset during wait of a write
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 32'hC; pwdata[1] = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    penable[1] = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    model_reset();
    rst = 1'b0;
    psel[1] = 1'b0; penable[1] = 1'b0;
    @(negedge clk);
    chk("rst_reg3", 1, 256'(regs[1][127:96]), 256'(0));
    chk("rst_rdy", 1, 256'(pready[1]), 256'(0));
    chk("rst_err", 1, 256'(err[1]), 256'(0));
    @(posedge clk); #1;

    // Randomised traffic
    for (int n = 0; n < 200; n++) begin
      int          k;
      bit          wr;
      logic [31:0] a;
      k  = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) a = $urandom | 32'h20;
      else a = 32'($urandom_range(0, 31));
      xfer(k, wr, a, $urandom, rd, lows);
      idle(int'($urandom_range(0, 2)));
    end

    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
